fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the PIGRO pipeline. It holds the 5-bit program counter, issues requests to instruction memory, buffers returned words in a 2-entry prefetch queue and presents one instruction plus its PC per cycle to the decode stage. It honours decode's `stall` (hold) and `jump_flag`/`jump_dest` (redirect and flush).

## Interface
- `PC_W`, 5: program counter / instruction memory address width.
- `DATA_W`, 32: instruction width.
- `NOP_WORD`, 32'h0000_0000: bubble inserted on flush/empty (opcode field 0 = NOP).
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset rst, synchronous, active-low; clock clk.
- `imem_req` out 1: one-cycle request strobe.
- `imem_addr` out PC_W: word address, valid while `imem_req`=1.
- `imem_valid` in 1: response strobe, ≥1 cycle after the request.
- `imem_rdata` in DATA_W: instruction word, valid with `imem_valid`.
- `stall` in 1: decode RAW stall; hold outputs.
- `jump_flag` in 1: decode redirect request.
- `jump_dest` in PC_W: redirect target.
- `instruction_out` out DATA_W: instruction to decode.
- `pc_out` out PC_W: PC of `instruction_out`.

## Operation
- State: `fetch_pc` (next address), `outstanding` (1 request in flight), `discard` (in-flight response belongs to a flushed path), 2-entry FIFO of {instr, pc}, output registers.
- FSM: IDLE (reset) -> FETCH on first cycle with rst=1. FETCH -> DRAIN on accepted jump while `outstanding`=1 and that response not returning this cycle; DRAIN -> FETCH when `imem_valid`=1 (word dropped). An accepted jump with nothing in flight stays in FETCH.
- Issue: in FETCH, `imem_req`=1 with `imem_addr`=`fetch_pc` when (`outstanding`=0 or `imem_valid`=1) and FIFO occupancy after this cycle's push/pop is ≤1. On issue `fetch_pc` <= `fetch_pc`+1, wraps 31 -> 0 modulo 2^PC_W. At most one request is in flight at any time.
- Response: `imem_valid` with `discard`=0 pushes {rdata, pc of the request} into the FIFO; with `discard`=1 the word is dropped and `discard` clears. An `imem_valid` while `outstanding`=0 is ignored.
- Output, `stall`=0, no jump: pop the FIFO head into `instruction_out`/`pc_out`. If the FIFO is empty and a non-discarded response arrives, it bypasses straight to the outputs. If neither exists, outputs get `NOP_WORD` and `pc_out` is held.
- `stall`=1: outputs hold, no pop. Requests continue only while FIFO space allows. `jump_flag` is ignored while `stall`=1.
- Jump accepted (`jump_flag`=1, `stall`=0): FIFO flushed. Outputs <= `NOP_WORD` with `pc_out` <= `jump_dest`. `fetch_pc` <= `jump_dest`. `discard` <= `outstanding` & ~`imem_valid`. No request is issued that cycle; the first request to `jump_dest` goes out on the next cycle if nothing is in flight, otherwise in the cycle the discarded response returns.
- FIFO overflow is impossible by the issue rule. Assertion: no push while full.

## Timing
- Reset values (rst=0 at edge): `fetch_pc`=0, FIFO empty, `outstanding`=0, `discard`=0, state IDLE, `imem_req`=0, `instruction_out`=`NOP_WORD`, `pc_out`=0.
- First request (addr 0) in the first cycle with rst=1.
- 1-cycle memory: request in cycle k, data on outputs after edge k+1, giving 1 instruction per cycle sustained.
- Latency L memory: throughput 1 per L cycles.
- Jump to first redirected instruction on outputs: 2 cycles with 1-cycle memory and nothing in flight. The intervening output is `NOP_WORD`.
- Reset asserted mid-operation overrides everything in the same edge. Any later `imem_valid` for a pre-reset request is ignored because `outstanding`=0.

## Test plan
- Reset then free-run with a 1-cycle memory holding word i = 32'h1000_0000+i -> `pc_out` 0,1,2,… on consecutive cycles with matching words. After pc 31, wraps to 0.
- `stall`=1 for 4 cycles while pc_out=3 -> outputs hold pc 3. FIFO fills to 2 and `imem_req` stops. On release, outputs give 4, 5, 6 back-to-back with no gap or duplicate.
- `jump_flag`=1, `jump_dest`=20 at pc_out=5 -> next output is `NOP_WORD`, then pc 20, 21. Buffered words for pc 6/7 are never output.
- Memory latency 3, jump while a request is in flight -> late word dropped (state DRAIN), no request in the meantime, next request addr=dest.
- `jump_flag`=1 and `stall`=1 together -> jump ignored, outputs held.
- rst=0 for one cycle mid-stream with a request in flight -> outputs `NOP_WORD`/pc 0, stale `imem_valid` ignored, refetch from addr 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Instruction-memory and decode-side signals of the PIGRO fetch stage.
// Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int PC_W   = 5,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_valid;
    logic [DATA_W-1:0] imem_rdata;
    logic              stall;
    logic              jump_flag;
    logic [PC_W-1:0]   jump_dest;
    logic [DATA_W-1:0] instruction_out;
    logic [PC_W-1:0]   pc_out;

    modport master (
        output imem_req, imem_addr, instruction_out, pc_out,
        input  imem_valid, imem_rdata, stall, jump_flag, jump_dest
    );

    modport slave (
        input  imem_req, imem_addr, instruction_out, pc_out,
        output imem_valid, imem_rdata, stall, jump_flag, jump_dest
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : PC, single-outstanding imem requests, 2-entry prefetch FIFO, decode output.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int                PC_W     = 5,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  wire logic    clk,
    input  wire logic    rst,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_fetch_pc;
    logic [PC_W-1:0]   r_req_pc;
    logic              r_outstanding;
    logic              r_discard;
    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_fifo_instr [2];
    logic [PC_W-1:0]   r_fifo_pc    [2];
    logic [DATA_W-1:0] r_instr;
    logic [PC_W-1:0]   r_pc;

    logic              w_jump;
    logic              w_resp;
    logic              w_resp_ok;
    logic              w_pop;
    logic              w_bypass;
    logic              w_push;
    logic              w_wr_idx;
    logic              w_issue;
    logic [1:0]        w_count_nxt;

    always_comb begin
        w_jump      = bus.jump_flag & ~bus.stall;
        w_resp      = bus.imem_valid & r_outstanding;
        w_resp_ok   = w_resp & ~r_discard;
        w_pop       = ~bus.stall & ~w_jump & (r_count != 2'd0);
        w_bypass    = ~bus.stall & ~w_jump & (r_count == 2'd0) & w_resp_ok;
        w_push      = w_resp_ok & ~w_jump & ~w_bypass;
        // Head sits at index 0; a push lands just behind whatever survives the pop.
        w_wr_idx    = (r_count == 2'd2) | ((r_count == 2'd1) & ~w_pop);
        w_count_nxt = w_jump ? 2'd0 : (r_count + {1'b0, w_push} - {1'b0, w_pop});
        w_issue     = rst & ~w_jump & (~r_outstanding | bus.imem_valid) & (w_count_nxt <= 2'd1);
    end

    assign bus.imem_req        = w_issue;
    assign bus.imem_addr       = r_fetch_pc;
    assign bus.instruction_out = r_instr;
    assign bus.pc_out          = r_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= '0;
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_count       <= 2'd0;
            r_instr       <= NOP_WORD;
            r_pc          <= '0;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_FETCH;
                S_FETCH: if (w_jump && r_outstanding && !bus.imem_valid) r_state <= S_DRAIN;
                S_DRAIN: if (bus.imem_valid) r_state <= S_FETCH;
                default: r_state <= S_IDLE;
            endcase

            if (w_issue) begin
                r_outstanding <= 1'b1;
                r_req_pc      <= r_fetch_pc;
            end else if (bus.imem_valid) begin
                r_outstanding <= 1'b0;
            end

            if (w_jump)      r_discard <= r_outstanding & ~bus.imem_valid;
            else if (w_resp) r_discard <= 1'b0;

            if (w_jump)       r_fetch_pc <= bus.jump_dest;
            else if (w_issue) r_fetch_pc <= r_fetch_pc + PC_W'(1);

            if (w_jump) begin
                r_count <= 2'd0;
            end else begin
                r_count <= w_count_nxt;
                if (w_pop) begin
                    r_fifo_instr[0] <= r_fifo_instr[1];
                    r_fifo_pc[0]    <= r_fifo_pc[1];
                end
                if (w_push) begin
                    r_fifo_instr[w_wr_idx] <= bus.imem_rdata;
                    r_fifo_pc[w_wr_idx]    <= r_req_pc;
                end
            end

            if (w_jump) begin
                r_instr <= NOP_WORD;
                r_pc    <= bus.jump_dest;
            end else if (!bus.stall) begin
                if (r_count != 2'd0) begin
                    r_instr <= r_fifo_instr[0];
                    r_pc    <= r_fifo_pc[0];
                end else if (w_resp_ok) begin
                    r_instr <= bus.imem_rdata;
                    r_pc    <= r_req_pc;
                end else begin
                    r_instr <= NOP_WORD;
                end
            end
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(w_push && (r_count == 2'd2)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Scoreboard bench: randomized stimulus, instruction-stream reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    localparam int          PC_W   = 5;
    localparam int          DATA_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

    fetch_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .NOP_WORD(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_deliv = 0;
    int cyc     = 0;
    int mem_lat = 1;
    bit mem_flush_on_rst = 1'b0;

    logic [31:0] mem [32];

    typedef struct {
        int        due;
        logic [4:0] addr;
    } req_t;
    req_t pend[$];

    // Reference model: the ordered stream of PCs decode should see next.
    logic [4:0]  exp_q[$];
    logic [4:0]  exp_next = 5'd0;
    logic        e_rst    = 1'b0;
    logic        e_stall  = 1'b0;
    logic        e_jump   = 1'b0;
    logic [4:0]  e_dest   = 5'd0;
    logic [31:0] cur_instr = NOP;
    logic [4:0]  cur_pc    = 5'd0;
    logic [4:0]  m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_out_pc(input logic [4:0] p);
        int k = 0;
        while (!(bus.pc_out == p && bus.instruction_out != NOP) && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_pc: pc_out never reached %0d", p);
        end
    endtask

    task automatic wait_req(input bit need_nonzero);
        int k = 0;
        @(negedge clk);
        while (!(bus.imem_req && (!need_nonzero || bus.imem_addr != 5'd0)) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_req: no request seen within 100 cycles");
        end
    endtask

    // Instruction memory with configurable latency.
    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.imem_valid = 1'b1;
                bus.imem_rdata = mem[pend[0].addr];
                void'(pend.pop_front());
            end else begin
                bus.imem_valid = 1'b0;
            end
            @(negedge clk);
            if (!rst && mem_flush_on_rst) pend.delete();
            if (bus.imem_req) pend.push_back('{due: cyc + mem_lat, addr: bus.imem_addr});
        end
    end

    // Reference: at every edge apply reset/redirect to the expected stream.
    initial begin
        forever begin
            @(posedge clk);
            e_rst   = rst;
            e_stall = bus.stall;
            e_jump  = bus.jump_flag;
            e_dest  = bus.jump_dest;
            if (!e_rst) begin
                exp_q.delete();
                exp_next = 5'd0;
            end else if (e_jump && !e_stall) begin
                exp_q.delete();
                exp_next = e_dest;
            end
            while (exp_q.size() < 40) begin
                exp_q.push_back(exp_next);
                exp_next = exp_next + 5'd1;
            end
        end
    end

    // Monitor: compare what the DUT presents against the expected stream.
    initial begin
        forever begin
            @(negedge clk);
            if (!e_rst) begin
                chk("reset_instr", bus.instruction_out, NOP);
                chk("reset_pc", 32'(bus.pc_out), 32'd0);
                cur_instr = NOP;
                cur_pc    = 5'd0;
            end else if (e_jump && !e_stall) begin
                chk("jump_nop", bus.instruction_out, NOP);
                chk("jump_pc", 32'(bus.pc_out), 32'(e_dest));
                cur_instr = NOP;
                cur_pc    = e_dest;
            end else if (e_stall) begin
                chk("stall_hold_instr", bus.instruction_out, cur_instr);
                chk("stall_hold_pc", 32'(bus.pc_out), 32'(cur_pc));
            end else if (bus.instruction_out != NOP) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stream: unexpected instruction 0x%08h at pc %0d", bus.instruction_out, bus.pc_out);
                end else begin
                    m_pc = exp_q.pop_front();
                    chk("stream_pc", 32'(bus.pc_out), 32'(m_pc));
                    chk("stream_instr", bus.instruction_out, mem[m_pc]);
                    cur_instr = mem[m_pc];
                    cur_pc    = m_pc;
                    n_deliv++;
                end
            end else begin
                chk("bubble_pc_hold", 32'(bus.pc_out), 32'(cur_pc));
                cur_instr = NOP;
            end
        end
    end

    // Driver
    initial begin
        int base;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
        bus.stall     = 1'b0;
        bus.jump_flag = 1'b0;
        bus.jump_dest = '0;
        rst           = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_no_req", 32'(bus.imem_req), 32'd0);

        // Release reset: first request to address 0 in the first active cycle.
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", 32'(bus.imem_addr), 32'd0);
        tick();
        tick();
        base = n_deliv;
        repeat (40) tick();
        chk("throughput_1cyc", 32'(n_deliv - base), 32'd40);

        // Stall four cycles at pc 3: FIFO fills, requests stop, then 4,5,6 back-to-back.
        wait_out_pc(5'd3);
        bus.stall = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("stall_req_stops_a", 32'(bus.imem_req), 32'd0);
        tick();
        @(negedge clk);
        chk("stall_req_stops_b", 32'(bus.imem_req), 32'd0);
        tick();
        bus.stall = 1'b0;
        base = n_deliv;
        repeat (4) tick();
        chk("stall_release_burst", 32'(n_deliv - base), 32'd3);

        // Jump at pc 5 to 20: NOP, then 20 two edges after the jump edge.
        wait_out_pc(5'd5);
        bus.jump_flag = 1'b1;
        bus.jump_dest = 5'd20;
        tick();
        bus.jump_flag = 1'b0;
        tick();
        tick();
        chk("jump_lat_pc", 32'(bus.pc_out), 32'd20);
        chk("jump_lat_instr", bus.instruction_out, mem[20]);

        // Latency-3 memory, jump while a request is in flight.
        mem_lat = 3;
        repeat (10) tick();
        wait_req(1'b0);
        tick();
        bus.jump_flag = 1'b1;
        bus.jump_dest = 5'd10;
        tick();
        bus.jump_flag = 1'b0;
        @(negedge clk);
        chk("drain_no_req", 32'(bus.imem_req), 32'd0);
        tick();
        @(negedge clk);
        chk("drain_req_on_return", 32'(bus.imem_req), 32'd1);
        chk("drain_req_addr", 32'(bus.imem_addr), 32'd10);
        repeat (12) tick();

        // Jump together with stall is ignored.
        bus.stall     = 1'b1;
        bus.jump_flag = 1'b1;
        bus.jump_dest = 5'd3;
        tick();
        bus.stall     = 1'b0;
        bus.jump_flag = 1'b0;
        repeat (10) tick();

        // One-cycle reset with a request in flight; the late response must be ignored.
        mem_lat = 2;
        repeat (6) tick();
        wait_req(1'b1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_refetch_req", 32'(bus.imem_req), 32'd1);
        chk("rst_refetch_addr", 32'(bus.imem_addr), 32'd0);
        @(negedge clk);
        chk("rst_stale_ignored", bus.instruction_out, NOP);
        repeat (10) tick();

        // Randomized traffic.
        mem_flush_on_rst = 1'b1;
        base = n_deliv;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (i % 100 == 0) mem_lat = $urandom_range(1, 3);
            bus.stall     = ($urandom_range(0, 3) == 0);
            bus.jump_flag = ($urandom_range(0, 11) == 0);
            bus.jump_dest = 5'($urandom_range(0, 31));
            rst           = ($urandom_range(0, 149) != 0);
        end
        tick();
        rst           = 1'b1;
        bus.stall     = 1'b0;
        bus.jump_flag = 1'b0;
        repeat (30) tick();
        chk("random_progress", 32'(n_deliv > base + 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
